// File: rtl/sad_min_search.sv
// sad_min_search: pipelined, handshaked minimum-SAD search over N_ROW rows of N_COL candidates
module sad_min_search #(
    parameter int SAD_W = 12,
    parameter int N_COL = 16,
    parameter int N_ROW = 16,
    parameter int COL_W = $clog2(N_COL),
    parameter int ROW_W = $clog2(N_ROW)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ROW_W-1:0]       in_row,
    input  logic [N_COL*SAD_W-1:0] in_sad,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SAD_W-1:0]       out_sad,
    output logic [COL_W-1:0]       out_mvx,
    output logic [ROW_W-1:0]       out_mvy,
    output logic                   busy
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t           state, state_nx;
    logic [ROW_W-1:0] cnt;
    logic             first;
    logic             s1_valid;
    logic [SAD_W-1:0] s1_min, best_sad, row_min;
    logic [COL_W-1:0] s1_col, best_col, row_col;
    logic [ROW_W-1:0] s1_row, best_row;
    logic             accept;
    logic             last;
    logic             launch;

    assign accept = in_valid && in_ready && !abort;
    assign last   = cnt == ROW_W'(N_ROW - 1);
    assign launch = state == IDLE && state_nx == SCAN;
    assign busy   = state != IDLE;

    // Row minimum; strict less-than keeps the lowest column on ties
    always_comb begin
        row_min = in_sad[SAD_W-1:0];
        row_col = '0;
        for (int c = 1; c < N_COL; c++) begin
            if (in_sad[c*SAD_W +: SAD_W] < row_min) begin
                row_min = in_sad[c*SAD_W +: SAD_W];
                row_col = COL_W'(c);
            end
        end
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? SCAN : IDLE;
            SCAN:    state_nx = (accept && last) ? DRAIN : SCAN;
            DRAIN:   state_nx = s1_valid ? DRAIN : DONE;
            DONE:    state_nx = (out_valid && out_ready) ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Registered handshake flags and row counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            cnt       <= '0;
            first     <= 1'b0;
        end else begin
            in_ready  <= state_nx == SCAN;
            out_valid <= state_nx == DONE;
            cnt       <= launch ? '0 : accept ? cnt + 1'b1 : cnt;
            first     <= launch ? 1'b1 : s1_valid ? 1'b0 : first;
        end
    end

    // Stage 1 captures the row minimum on each accepted row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_min   <= '0;
            s1_col   <= '0;
            s1_row   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_min <= row_min;
                s1_col <= row_col;
                s1_row <= in_row;
            end
        end
    end

    // Stage 2 folds rows into the running best; first row is force-loaded, later ties keep the earlier row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_sad <= '0;
            best_col <= '0;
            best_row <= '0;
        end else if (s1_valid && !abort && (first || s1_min < best_sad)) begin
            best_sad <= s1_min;
            best_col <= s1_col;
            best_row <= s1_row;
        end
    end

    // Result registers load once on entry to DONE and survive an abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sad <= '0;
            out_mvx <= '0;
            out_mvy <= '0;
        end else if (state == DRAIN && state_nx == DONE) begin
            out_sad <= best_sad;
            out_mvx <= best_col;
            out_mvy <= best_row;
        end
    end
endmodule

// File: tb/tb_sad_min_search.sv
// tb_sad_min_search: directed self-checking bench for sad_min_search
module tb_sad_min_search;
    localparam int SAD_W = 12;
    localparam int N_COL = 16;
    localparam int N_ROW = 16;
    localparam int COL_W = 4;
    localparam int ROW_W = 4;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic                   abort = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   out_ready = 1'b0;
    logic [ROW_W-1:0]       in_row = '0;
    logic [N_COL*SAD_W-1:0] in_sad = '0;
    logic                   in_ready, out_valid, busy;
    logic [SAD_W-1:0]       out_sad;
    logic [COL_W-1:0]       out_mvx;
    logic [ROW_W-1:0]       out_mvy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int k;
    logic [SAD_W-1:0] tab [N_ROW][N_COL];

    sad_min_search #(.SAD_W(SAD_W), .N_COL(N_COL), .N_ROW(N_ROW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row), .in_sad(in_sad),
        .out_valid(out_valid), .out_ready(out_ready), .out_sad(out_sad),
        .out_mvx(out_mvx), .out_mvy(out_mvy), .busy(busy)
    );

    always #5 clk = ~clk;

    // Cycle counter used to measure result latency
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [SAD_W-1:0] v);
        for (int r = 0; r < N_ROW; r++)
            for (int c = 0; c < N_COL; c++)
                tab[r][c] = v;
    endtask

    task automatic start_search();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_row(input int r, input int gap);
        int t;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        in_valid = 1'b1;
        in_row = ROW_W'(r);
        for (int c = 0; c < N_COL; c++) in_sad[c*SAD_W +: SAD_W] = tab[r][c];
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t == 50) check("accept_timeout", in_ready, 1);
        @(negedge clk);
    endtask

    task automatic wait_result(input string tag, input int kk);
        int t;
        t = 0;
        while (!out_valid && t < 60) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_valid"}, out_valid, 1);
        if (kk >= 0) check({tag, "_latency"}, cyc - kk, 2);
    endtask

    task automatic expect_result(input string tag, input int s, input int x, input int y);
        check({tag, "_sad"}, out_sad, s);
        check({tag, "_mvx"}, out_mvx, x);
        check({tag, "_mvy"}, out_mvy, y);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ov_low"}, out_valid, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        expect_result("rst", 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single clear minimum, back-to-back rows, latency
        fill(100);
        tab[5][9] = 3;
        start_search();
        check("t1_busy", busy, 1);
        for (int r = 0; r < N_ROW; r++) send_row(r, 0);
        k = cyc;
        in_valid = 1'b0;
        check("t1_ready_drop", in_ready, 0);
        wait_result("t1", k);
        expect_result("t1", 3, 9, 5);
        handshake("t1");

        // ties: lowest column, then earliest row
        fill(50);
        tab[2][4] = 7;
        tab[2][1] = 7;
        tab[9][0] = 7;
        start_search();
        for (int r = 0; r < N_ROW; r++) send_row(r, 0);
        k = cyc;
        in_valid = 1'b0;
        wait_result("t2", k);
        expect_result("t2", 7, 1, 2);
        handshake("t2");

        // all maximum, rows presented in reverse: first accepted row is kept
        fill(12'hFFF);
        start_search();
        for (int r = N_ROW - 1; r >= 0; r--) send_row(r, 0);
        in_valid = 1'b0;
        wait_result("t3", -1);
        expect_result("t3", 12'hFFF, 0, 15);
        handshake("t3");

        // random gaps, consumer stall, start ignored in DONE
        fill(200);
        tab[3][15] = 20;
        tab[11][15] = 20;
        start_search();
        for (int r = 0; r < N_ROW; r++) send_row(r, int'($urandom_range(0, 2)));
        in_valid = 1'b0;
        wait_result("t4", -1);
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            @(negedge clk);
            check("t4_hold_valid", out_valid, 1);
            check("t4_hold_sad", out_sad, 20);
        end
        start = 1'b0;
        expect_result("t4", 20, 15, 3);
        start = 1'b1;
        handshake("t4");
        start = 1'b0;
        @(negedge clk);
        check("t4_no_restart_ready", in_ready, 0);
        check("t4_no_restart_busy", busy, 0);

        // abort after 7 rows, then a fresh search
        fill(90);
        tab[3][2] = 1;
        start_search();
        for (int r = 0; r < 7; r++) send_row(r, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        in_valid = 1'b0;
        check("t5_abort_ready", in_ready, 0);
        check("t5_abort_busy", busy, 0);
        check("t5_abort_ov", out_valid, 0);
        check("t5_abort_keep_sad", out_sad, 20);
        repeat (5) @(negedge clk);
        check("t5_abort_ov_later", out_valid, 0);
        fill(80);
        tab[14][6] = 30;
        start_search();
        for (int r = 0; r < N_ROW; r++) send_row(r, 0);
        k = cyc;
        in_valid = 1'b0;
        wait_result("t5", k);
        expect_result("t5", 30, 6, 14);
        handshake("t5");

        // asynchronous reset mid-scan
        fill(60);
        start_search();
        for (int r = 0; r < 4; r++) send_row(r, 0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_ready", in_ready, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ov", out_valid, 0);
        expect_result("t6_rst", 0, 0, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_ready_stays_low", in_ready, 0);
        check("t6_busy_stays_low", busy, 0);
        in_valid = 1'b0;

        // corner position: last column of last row
        fill(9);
        tab[15][15] = 2;
        start_search();
        for (int r = 0; r < N_ROW; r++) send_row(r, 0);
        k = cyc;
        in_valid = 1'b0;
        wait_result("t7", k);
        expect_result("t7", 2, 15, 15);
        handshake("t7");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sad_min_search.md
# sad_min_search

Parametrised minimum-SAD search engine for the full-search block-matching datapath. It consumes one search-window row of N_COL candidate SAD values per handshake from the SAD array. It tracks the global minimum over N_ROW rows and returns the winning SAD with its (mvx, mvy) displacement through a valid/ready output. It sits between the SAD accumulator array and the motion-vector writer. It replaces the fixed 16-candidate, single-cycle comparator with a pipelined, handshaked, deterministic-tie-break design.

## Interface
Parameters:
- SAD_W, 12, width of one SAD value
- N_COL, 16, candidates per row (horizontal search positions), ≥2
- N_ROW, 16, rows per search (vertical search positions), ≥1
- COL_W, $clog2(N_COL), width of mvx
- ROW_W, $clog2(N_ROW), width of mvy / in_row

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin new search; honoured only in IDLE
- abort  in  1  synchronous cancel; returns to IDLE from any state
- in_valid  in  1  row data valid
- in_ready  out  1  engine accepts a row this cycle
- in_row  in  ROW_W  vertical index of the presented row
- in_sad  in  N_COL*SAD_W  packed SADs; column c at bits [c*SAD_W +: SAD_W]
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sad  out  SAD_W  minimum SAD
- out_mvx  out  COL_W  column index of minimum
- out_mvy  out  ROW_W  in_row of minimum
- busy  out  1  high in SCAN, DRAIN, DONE

## Operation
- States: IDLE, SCAN, DRAIN, DONE. Reset → IDLE.
- IDLE: start=1 → SCAN. On the same edge, row counter cnt clears to 0 and the first-row flag is set.
- SCAN: in_ready=1. Accept occurs on an edge where in_valid&in_ready. Each accept increments cnt. The accept with cnt==N_ROW-1 → DRAIN, and in_ready drops on the following cycle.
- Stage 1, registered on the accept edge: combinational min over N_COL columns. Strict less-than, so the lowest column index wins ties. Registers row_min, row_col, in_row and a stage-valid bit.
- Stage 2, the edge after stage 1: if the first-row flag is set, load best from stage 1 unconditionally and clear the flag. Otherwise replace best only when row_min < best_sad (strict), so the earliest accepted row wins ties.
- DRAIN: wait until stage 1 and stage 2 have retired, then → DONE.
- DONE: out_valid=1 with out_sad/out_mvx/out_mvy = best. Hold stable until out_valid&out_ready, then → IDLE with out_valid low the next cycle.
- in_row is not checked or reordered. Rows may arrive in any order; mvy reports the in_row value as presented.
- abort takes priority over every other event. On the next edge: state → IDLE, pipeline valid bits clear, out_valid=0, in_ready=0. Output data registers keep their values.
- start is ignored in SCAN, DRAIN and DONE. A start asserted on the same edge as the DONE handshake is also ignored; it must be reasserted in IDLE.
- in_valid low in SCAN stalls the engine without limit; no timeout.
- Widths: comparisons are unsigned SAD_W bits; no arithmetic beyond compare.

## Timing
- Reset values: in_ready=0, out_valid=0, busy=0, out_sad=0, out_mvx=0, out_mvy=0. Internal best, cnt and pipeline valids are all 0.
- in_ready is registered and rises the cycle after the start edge.
- Throughput: one row per cycle in SCAN.
- Latency: the final row is accepted at edge k, stage 1 updates at k, stage 2 at k+1, DRAIN→DONE at k+2. out_valid is first high in the cycle after edge k+2.
- A result is N_ROW+3 cycles after start for back-to-back rows.
- Outputs are registered; no combinational path from in_* to out_*.
- Async reset mid-search: immediate return to reset values; the partial result is discarded.

## Test plan
- N_ROW=16, N_COL=16. Rows 0..15 back-to-back, all SADs 100 except row 5 col 9 = 3. Required: out_sad=3, mvx=9, mvy=5; out_valid first high at the cycle after edge k+2.
- Ties: row 2 col 4 = 7, row 2 col 1 = 7, row 9 col 0 = 7, all others 50. Required: mvx=1, mvy=2 (lowest column, then earliest row).
- All SADs 12'hFFF. Required: out_sad=FFF, mvx=0, mvy equal to the first accepted in_row. This proves the first row is force-loaded.
- Random in_valid gaps plus out_ready held low for 10 cycles. Required: result unchanged, out_valid stays high, start pulses in DONE are ignored, IDLE follows the handshake.
- abort after 7 rows, then a fresh start with new data. Required: no out_valid from the aborted search; the new result depends only on new rows.
- rst_n low mid-SCAN for 1 cycle. Required: all outputs at reset values immediately; in_ready stays 0 until the next start.
